// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - parametrised register file with bypass, zero register and busy scoreboard
//
// Purpose: DEPTH x WIDTH register file between decode and writeback. Two
// combinational read ports return operand data and a pending-write (busy)
// flag. A clocked write port commits results and clears busy. An issue
// port marks a destination register busy. A registered counter tracks how
// many registers are busy.
//
// Parameters:
//   WIDTH    - data width of each register
//   ADDR_W   - address width, DEPTH = 2**ADDR_W
//   ZERO_REG - 1: register 0 reads 0 and ignores writes and issues
//   BYPASS   - 1: a write in the current cycle is forwarded to the read ports
//
// Ports:
//   i_clk         clock, rising edge
//   i_rst_n       asynchronous active-low reset, clears all state
//   i_rd_addr1/2  read port addresses
//   o_rd_data1/2  read port data (combinational)
//   o_rd_busy1/2  read port register has a pending write
//   i_wr_en       commit i_wr_data to i_wr_addr at next rising edge
//   i_wr_addr     write address
//   i_wr_data     write data
//   i_issue_en    mark i_issue_addr busy at next rising edge
//   i_issue_addr  destination register being issued
//   o_busy_count  number of registers currently busy

module reg_file_sb #(
    parameter int WIDTH    = 32,
    parameter int ADDR_W   = 2,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [ADDR_W-1:0] i_rd_addr1,
    input  logic [ADDR_W-1:0] i_rd_addr2,
    output logic [WIDTH-1:0]  o_rd_data1,
    output logic [WIDTH-1:0]  o_rd_data2,
    output logic              o_rd_busy1,
    output logic              o_rd_busy2,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]  i_wr_data,
    input  logic              i_issue_en,
    input  logic [ADDR_W-1:0] i_issue_addr,
    output logic [ADDR_W:0]   o_busy_count
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0] r_busy;
    logic [ADDR_W:0]  r_busy_count;

    logic w_wr_ok;
    logic w_issue_ok;
    logic w_inc;
    logic w_dec;

    // Accesses to a hard-wired zero register are dropped before they reach state.
    assign w_wr_ok    = i_wr_en    && !((ZERO_REG != 0) && (i_wr_addr    == '0));
    assign w_issue_ok = i_issue_en && !((ZERO_REG != 0) && (i_issue_addr == '0));

    // Counter tracks the busy vector incrementally. An issue to the address
    // being written keeps the bit set, so that write does not decrement.
    assign w_inc = w_issue_ok && !r_busy[i_issue_addr];
    assign w_dec = w_wr_ok && r_busy[i_wr_addr]
                   && !(w_issue_ok && (i_issue_addr == i_wr_addr));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
            r_busy       <= '0;
            r_busy_count <= '0;
        end else begin
            if (w_wr_ok) begin
                r_regs[i_wr_addr] <= i_wr_data;
                r_busy[i_wr_addr] <= 1'b0;
            end
            // Issue is applied after the write so it wins on the same address.
            if (w_issue_ok) begin
                r_busy[i_issue_addr] <= 1'b1;
            end
            r_busy_count <= r_busy_count
                            + {{ADDR_W{1'b0}}, w_inc}
                            - {{ADDR_W{1'b0}}, w_dec};
        end
    end

    // Read port 1: array -> bypass override -> zero register -> reset gating.
    always_comb begin
        o_rd_data1 = r_regs[i_rd_addr1];
        o_rd_busy1 = r_busy[i_rd_addr1];
        if ((BYPASS != 0) && w_wr_ok && (i_wr_addr == i_rd_addr1)) begin
            o_rd_data1 = i_wr_data;
            o_rd_busy1 = 1'b0;
        end
        if ((ZERO_REG != 0) && (i_rd_addr1 == '0)) begin
            o_rd_data1 = '0;
            o_rd_busy1 = 1'b0;
        end
        // Bypass would otherwise leak wr_data while reset is held.
        if (!i_rst_n) begin
            o_rd_data1 = '0;
            o_rd_busy1 = 1'b0;
        end
    end

    // Read port 2: identical to port 1.
    always_comb begin
        o_rd_data2 = r_regs[i_rd_addr2];
        o_rd_busy2 = r_busy[i_rd_addr2];
        if ((BYPASS != 0) && w_wr_ok && (i_wr_addr == i_rd_addr2)) begin
            o_rd_data2 = i_wr_data;
            o_rd_busy2 = 1'b0;
        end
        if ((ZERO_REG != 0) && (i_rd_addr2 == '0)) begin
            o_rd_data2 = '0;
            o_rd_busy2 = 1'b0;
        end
        if (!i_rst_n) begin
            o_rd_data2 = '0;
            o_rd_busy2 = 1'b0;
        end
    end

    assign o_busy_count = r_busy_count;

endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - directed self-checking bench for reg_file_sb

module tb_reg_file_sb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  rd_addr1, rd_addr2, wr_addr, issue_addr;
    logic [31:0] wr_data;
    logic        wr_en, issue_en;

    logic [31:0] b_d1, b_d2, n_d1, n_d2, z_d1, z_d2;
    logic        b_b1, b_b2, n_b1, n_b2, z_b1, z_b2;
    logic [2:0]  b_cnt, n_cnt, z_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    reg_file_sb #(.WIDTH(32), .ADDR_W(2), .ZERO_REG(0), .BYPASS(1)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_rd_addr1(rd_addr1), .i_rd_addr2(rd_addr2),
        .o_rd_data1(b_d1), .o_rd_data2(b_d2),
        .o_rd_busy1(b_b1), .o_rd_busy2(b_b2),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_issue_en(issue_en), .i_issue_addr(issue_addr),
        .o_busy_count(b_cnt));

    reg_file_sb #(.WIDTH(32), .ADDR_W(2), .ZERO_REG(0), .BYPASS(0)) dut_n (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_rd_addr1(rd_addr1), .i_rd_addr2(rd_addr2),
        .o_rd_data1(n_d1), .o_rd_data2(n_d2),
        .o_rd_busy1(n_b1), .o_rd_busy2(n_b2),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_issue_en(issue_en), .i_issue_addr(issue_addr),
        .o_busy_count(n_cnt));

    reg_file_sb #(.WIDTH(32), .ADDR_W(2), .ZERO_REG(1), .BYPASS(1)) dut_z (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_rd_addr1(rd_addr1), .i_rd_addr2(rd_addr2),
        .o_rd_data1(z_d1), .o_rd_data2(z_d2),
        .o_rd_busy1(z_b1), .o_rd_busy2(z_b2),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_issue_en(issue_en), .i_issue_addr(issue_addr),
        .o_busy_count(z_cnt));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wr_en = 1'b0; issue_en = 1'b0;
        wr_addr = 2'd0; wr_data = 32'h0; issue_addr = 2'd0;
        rd_addr1 = 2'd0; rd_addr2 = 2'd0;
        step(); step();
        rst_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            rd_addr1 = a[1:0]; rd_addr2 = a[1:0];
            #1;
            n_cmp++; if (b_d1 !== 32'h0 || b_d2 !== 32'h0) begin n_fail++;
                $display("FAIL reset_data addr %0d: got %h/%h want 0", a, b_d1, b_d2); end
            n_cmp++; if (b_b1 !== 1'b0 || b_b2 !== 1'b0 || n_b1 !== 1'b0) begin n_fail++;
                $display("FAIL reset_busy addr %0d: got %b/%b/%b want 0", a, b_b1, b_b2, n_b1); end
        end
        n_cmp++; if (b_cnt !== 3'd0 || n_cnt !== 3'd0 || z_cnt !== 3'd0) begin n_fail++;
            $display("FAIL reset_count: got %0d/%0d/%0d want 0", b_cnt, n_cnt, z_cnt); end
    endtask

    task automatic test_basic_write();
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = 32'd1; step();
        wr_addr = 2'd3; wr_data = 32'd4; step();
        wr_en = 1'b0;
        rd_addr1 = 2'd0; rd_addr2 = 2'd3; #1;
        n_cmp++; if (b_d1 !== 32'd1 || b_d2 !== 32'd4) begin n_fail++;
            $display("FAIL basic_read_byp: got %0d,%0d want 1,4", b_d1, b_d2); end
        n_cmp++; if (n_d1 !== 32'd1 || n_d2 !== 32'd4) begin n_fail++;
            $display("FAIL basic_read_nobyp: got %0d,%0d want 1,4", n_d1, n_d2); end
        wr_addr = 2'd0; wr_data = 32'hDEAD_BEEF; step();
        n_cmp++; if (b_d1 !== 32'd1 || n_d1 !== 32'd1) begin n_fail++;
            $display("FAIL write_disabled: got %h/%h want 1", b_d1, n_d1); end
    endtask

    task automatic test_scoreboard();
        issue_en = 1'b1; issue_addr = 2'd2; step();
        issue_en = 1'b0; rd_addr1 = 2'd2; #1;
        n_cmp++; if (b_b1 !== 1'b1 || n_b1 !== 1'b1) begin n_fail++;
            $display("FAIL issue_busy: got %b/%b want 1", b_b1, n_b1); end
        n_cmp++; if (b_cnt !== 3'd1 || n_cnt !== 3'd1) begin n_fail++;
            $display("FAIL issue_count: got %0d/%0d want 1", b_cnt, n_cnt); end
        wr_en = 1'b1; wr_addr = 2'd2; wr_data = 32'd7; #1;
        n_cmp++; if (b_d1 !== 32'd7 || b_b1 !== 1'b0) begin n_fail++;
            $display("FAIL pre_edge_byp: got %0d busy %b want 7 busy 0", b_d1, b_b1); end
        n_cmp++; if (n_d1 !== 32'd0 || n_b1 !== 1'b1) begin n_fail++;
            $display("FAIL pre_edge_nobyp: got %0d busy %b want 0 busy 1", n_d1, n_b1); end
        step(); wr_en = 1'b0; #1;
        n_cmp++; if (n_d1 !== 32'd7 || n_b1 !== 1'b0 || n_cnt !== 3'd0) begin n_fail++;
            $display("FAIL write_clears: got %0d busy %b cnt %0d want 7 0 0", n_d1, n_b1, n_cnt); end
        wr_en = 1'b1; wr_addr = 2'd1; wr_data = 32'h11;
        issue_en = 1'b1; issue_addr = 2'd1; step();
        wr_en = 1'b0; issue_en = 1'b0; rd_addr1 = 2'd1; #1;
        n_cmp++; if (b_d1 !== 32'h11 || b_b1 !== 1'b1 || b_cnt !== 3'd1) begin n_fail++;
            $display("FAIL issue_wins: got %h busy %b cnt %0d want 11 1 1", b_d1, b_b1, b_cnt); end
        wr_en = 1'b1; wr_addr = 2'd1; wr_data = 32'h22;
        issue_en = 1'b1; issue_addr = 2'd3; step();
        wr_en = 1'b0; issue_en = 1'b0; rd_addr2 = 2'd3; #1;
        n_cmp++; if (n_b1 !== 1'b0 || n_b2 !== 1'b1 || n_cnt !== 3'd1) begin n_fail++;
            $display("FAIL net_zero: got busy1 %b busy3 %b cnt %0d want 0 1 1", n_b1, n_b2, n_cnt); end
        n_cmp++; if (n_d1 !== 32'h22) begin n_fail++;
            $display("FAIL net_zero_data: got %h want 22", n_d1); end
    endtask

    task automatic test_bypass();
        rd_addr1 = 2'd3; rd_addr2 = 2'd3;
        wr_en = 1'b1; wr_addr = 2'd3; wr_data = 32'hA5A5_A5A5; #1;
        n_cmp++; if (b_d1 !== 32'hA5A5_A5A5 || b_d2 !== 32'hA5A5_A5A5 || b_b1 !== 1'b0) begin n_fail++;
            $display("FAIL bypass_on: got %h/%h busy %b want a5a5a5a5 busy 0", b_d1, b_d2, b_b1); end
        n_cmp++; if (n_d1 !== 32'd4 || n_b1 !== 1'b1) begin n_fail++;
            $display("FAIL bypass_off_old: got %h busy %b want 4 busy 1", n_d1, n_b1); end
        step(); wr_en = 1'b0; #1;
        n_cmp++; if (n_d1 !== 32'hA5A5_A5A5 || n_b1 !== 1'b0 || n_cnt !== 3'd0) begin n_fail++;
            $display("FAIL bypass_off_new: got %h busy %b cnt %0d want a5a5a5a5 0 0", n_d1, n_b1, n_cnt); end
    endtask

    task automatic test_zero_reg();
        rst_n = 1'b0; #1; rst_n = 1'b1;
        issue_en = 1'b1; issue_addr = 2'd2; step();
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = 32'hFFFF_FFFF;
        issue_addr = 2'd0; rd_addr1 = 2'd0; #1;
        n_cmp++; if (z_d1 !== 32'h0 || z_b1 !== 1'b0) begin n_fail++;
            $display("FAIL zero_pre_edge: got %h busy %b want 0 0", z_d1, z_b1); end
        step(); wr_en = 1'b0; issue_en = 1'b0; #1;
        n_cmp++; if (z_d1 !== 32'h0 || z_b1 !== 1'b0 || z_cnt !== 3'd1) begin n_fail++;
            $display("FAIL zero_reg: got %h busy %b cnt %0d want 0 0 1", z_d1, z_b1, z_cnt); end
        n_cmp++; if (b_d1 !== 32'hFFFF_FFFF || b_b1 !== 1'b1 || b_cnt !== 3'd2) begin n_fail++;
            $display("FAIL nonzero_reg0: got %h busy %b cnt %0d want ffffffff 1 2", b_d1, b_b1, b_cnt); end
    endtask

    task automatic test_async_reset();
        for (int a = 0; a < 4; a++) begin
            wr_en = 1'b1; wr_addr = a[1:0]; wr_data = 32'h100 + a;
            issue_en = 1'b1; issue_addr = a[1:0];
            step();
        end
        wr_en = 1'b0; issue_en = 1'b0; rd_addr1 = 2'd2; rd_addr2 = 2'd3; #1;
        n_cmp++; if (b_cnt !== 3'd4 || n_cnt !== 3'd4 || z_cnt !== 3'd3) begin n_fail++;
            $display("FAIL full_count: got %0d/%0d/%0d want 4/4/3", b_cnt, n_cnt, z_cnt); end
        n_cmp++; if (b_d1 !== 32'h102 || b_d2 !== 32'h103 || b_b1 !== 1'b1) begin n_fail++;
            $display("FAIL full_data: got %h/%h busy %b want 102/103 1", b_d1, b_d2, b_b1); end
        #2; rst_n = 1'b0;
        wr_en = 1'b1; wr_addr = 2'd2; wr_data = 32'h5555_5555; #1;
        n_cmp++; if (b_cnt !== 3'd0 || n_cnt !== 3'd0 || z_cnt !== 3'd0) begin n_fail++;
            $display("FAIL async_count: got %0d/%0d/%0d want 0", b_cnt, n_cnt, z_cnt); end
        n_cmp++; if (b_d1 !== 32'h0 || b_d2 !== 32'h0 || b_b1 !== 1'b0 || n_b2 !== 1'b0) begin n_fail++;
            $display("FAIL async_outputs: got %h/%h busy %b/%b want 0", b_d1, b_d2, b_b1, n_b2); end
        wr_en = 1'b0; #1; rst_n = 1'b1;
        wr_en = 1'b1; wr_addr = 2'd1; wr_data = 32'h55; step();
        wr_en = 1'b0; rd_addr1 = 2'd1; #1;
        n_cmp++; if (n_d1 !== 32'h55 || n_d2 !== 32'h0) begin n_fail++;
            $display("FAIL first_write: got %h/%h want 55/0", n_d1, n_d2); end
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_scoreboard();
        test_bypass();
        test_zero_reg();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised multi-register file with two combinational read ports, one clocked write port, optional write-to-read bypass, optional hard-wired zero register, and a per-register busy scoreboard. Successor to the fixed 4×32 register file. It sits between the decode and writeback stages of the single-cycle/pipelined datapath. Decode uses it to read operands and detect pending writes, and writeback uses it to commit results.

## Interface
- WIDTH, 32, data width of each register
- ADDR_W, 2, address width; DEPTH = 2**ADDR_W registers
- ZERO_REG, 0, 1 = register 0 always reads 0 and ignores writes and issues
- BYPASS, 1, 1 = a same-cycle write is forwarded to read ports

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-low; clears all state
- rd_addr1  input  ADDR_W  read port 1 address
- rd_addr2  input  ADDR_W  read port 2 address
- rd_data1  output  WIDTH  read port 1 data (combinational)
- rd_data2  output  WIDTH  read port 2 data (combinational)
- rd_busy1  output  1  register at rd_addr1 has a pending write
- rd_busy2  output  1  register at rd_addr2 has a pending write
- wr_en  input  1  commit wr_data to wr_addr at next rising edge
- wr_addr  input  ADDR_W  write address
- wr_data  input  WIDTH  write data
- issue_en  input  1  mark issue_addr busy at next rising edge
- issue_addr  input  ADDR_W  destination register being issued
- busy_count  output  ADDR_W+1  number of registers currently busy

## Operation
- Storage: DEPTH × WIDTH registers and a DEPTH-bit busy vector.
- Reset (reset=0, asynchronous): all registers are 0, all busy bits are 0, busy_count is 0. Reads during reset return 0, and rd_busy is 0.
- Write: on a rising edge with wr_en=1, reg[wr_addr] <= wr_data and busy[wr_addr] <= 0.
- Issue: on a rising edge with issue_en=1, busy[issue_addr] <= 1.
- Issue and write to the same address in one cycle: the data is written and busy ends at 1, so issue wins because it marks a newer producer.
- Issue and write to different addresses: both take effect independently.
- Write to an address that is not busy: the data is written and busy stays 0. This is legal.
- ZERO_REG=1: writes and issues to address 0 are dropped, rd_data for address 0 is 0, and rd_busy for address 0 is 0.
- Read, BYPASS=0: rd_dataN = reg[rd_addrN] and rd_busyN = busy[rd_addrN].
- Read, BYPASS=1: if wr_en=1 and wr_addr==rd_addrN (and the address is not a zeroed reg 0):
  - rd_dataN = wr_data
  - rd_busyN = 0
  - Otherwise the port behaves as in the BYPASS=0 case.
- Both read ports may address the same register and return identical values.
- busy_count: registered popcount of the busy vector, updated on the same edge as the vector. It has its own counter with a +1 / −1 / 0 rule:
  - +1 when an issue sets a bit that was 0.
  - −1 when a write clears a bit that was 1 (and no issue to that address in the cycle).
  - Two changes in one cycle: they net out, so both issue-set and write-clear on different addresses gives 0.
  - Never exceeds DEPTH (or DEPTH−1 with ZERO_REG=1).

## Timing
- Read latency: 0 cycles (combinational from rd_addr, and from wr_* when BYPASS=1).
- Write/issue latency: the effect is visible on the non-bypassed read path and on busy_count after 1 rising edge.
- Reset asserted mid-cycle: state clears immediately, without waiting for clk. Release is synchronous-safe; the first write is honoured on the first rising edge after reset=1.
- No handshake; wr_en and issue_en are sampled only at rising edges.

## Test plan
- Reset: hold reset=0, then release. Read all addresses -> rd_data=0, rd_busy=0, busy_count=0.
- Basic write/read (WIDTH=32, ADDR_W=2): write 32'd1 to reg 0 and 32'd4 to reg 3, then deassert wr_en. Read (0,3) -> 1, 4. Change wr_data while wr_en=0 -> reg contents unchanged.
- Scoreboard: issue reg 2 -> rd_busy for addr 2 is 1 and busy_count=1. Next, write reg 2 = 32'd7 -> busy 0, busy_count=0, read 7. Then issue and write reg 1 in the same cycle -> busy stays 1, data updated, busy_count=1.
- Bypass: BYPASS=1, with rd_addr1=wr_addr=3, wr_en=1, wr_data=32'hA5A5A5A5 -> rd_data1=32'hA5A5A5A5 in the same cycle before the edge. With BYPASS=0 -> rd_data1 shows the old value until after the edge.
- Zero register: ZERO_REG=1. Write 32'hFFFFFFFF and issue to reg 0 -> read 0, busy 0, busy_count unchanged.
- Async reset mid-operation: fill all 4 regs and issue all -> busy_count=4. Pulse reset=0 between clock edges -> outputs immediately 0 and busy_count=0.
